// File: rtl/alu_exec_stage_pkg.sv
// Shared definitions for the accumulator execute stage: opcode encoding,
// default data width and the stage FSM state type.
package alu_exec_stage_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Opcode encoding shared with the decode stage; E and F are both NOP.
    typedef enum logic [3:0] {
        OP_LD   = 4'h0,
        OP_AND  = 4'h1,
        OP_OR   = 4'h2,
        OP_XOR  = 4'h3,
        OP_NOT  = 4'h4,
        OP_ADD  = 4'h5,
        OP_SUB  = 4'h6,
        OP_GT   = 4'h7,
        OP_EQ   = 4'h8,
        OP_LT   = 4'h9,
        OP_MUL  = 4'hA,
        OP_DIV  = 4'hB,
        OP_SHL  = 4'hC,
        OP_SHR  = 4'hD,
        OP_NOP  = 4'hE,
        OP_NOP2 = 4'hF
    } opCodeT;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } stageStateT;

endpackage

// File: rtl/seq_muldiv_unit.sv
// Iterative multiplier / restoring divider, one bit per clock edge.
// The first iteration is performed on the start edge directly from the
// input operands, so the final iteration lands on the WIDTH-th edge and
// 'done' is raised combinationally in the cycle leading up to it; lo/hi
// carry the finished result during that cycle only.
module seq_muldiv_unit
    import alu_exec_stage_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             isDiv,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             divZero
);

    localparam int CW = $clog2(WIDTH + 1);

    // Work register: MUL holds {partial high, multiplier/low product},
    // DIV holds {remainder, dividend/quotient}. Both start as {0, A}.
    logic [2*WIDTH-1:0] workReg;
    logic [2*WIDTH-1:0] workSrc;
    logic [2*WIDTH-1:0] workStep;
    logic [WIDTH-1:0]   bReg;
    logic [WIDTH-1:0]   bSrc;
    logic               isDivReg;
    logic               isDivSrc;
    logic               busyReg;
    logic [CW-1:0]      countReg;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic [WIDTH:0]     divDiff;
    logic               active;

    // Division by zero is resolved by the caller without iterating.
    assign divZero = isDiv && (b == '0);
    assign active  = busyReg || (start && !divZero);
    assign done    = busyReg && (countReg == CW'(WIDTH - 1));
    assign lo      = workStep[WIDTH-1:0];
    assign hi      = workStep[2*WIDTH-1:WIDTH];

    // Iteration source: fresh operands on the start edge, registers afterwards.
    always_comb begin
        workSrc  = workReg;
        bSrc     = bReg;
        isDivSrc = isDivReg;
        if (!busyReg) begin
            workSrc  = {{WIDTH{1'b0}}, a};
            bSrc     = b;
            isDivSrc = isDiv;
        end
    end

    // One shift-add or one restoring-divide step.
    always_comb begin
        mulSum   = {1'b0, workSrc[2*WIDTH-1:WIDTH]}
                 + (workSrc[0] ? {1'b0, bSrc} : {(WIDTH+1){1'b0}});
        divShift = workSrc[2*WIDTH-1:WIDTH-1];
        divDiff  = divShift - {1'b0, bSrc};
        if (isDivSrc) begin
            // Remainder stays below the divisor, so bit WIDTH of the
            // difference is a reliable "trial went negative" indicator.
            if (divDiff[WIDTH]) begin
                workStep = {divShift[WIDTH-1:0], workSrc[WIDTH-2:0], 1'b0};
            end else begin
                workStep = {divDiff[WIDTH-1:0], workSrc[WIDTH-2:0], 1'b1};
            end
        end else begin
            workStep = {mulSum, workSrc[WIDTH-1:1]};
        end
    end

    // Iteration registers and counter; operands captured on the start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            workReg  <= '0;
            bReg     <= '0;
            isDivReg <= 1'b0;
            busyReg  <= 1'b0;
            countReg <= '0;
        end else if (active) begin
            workReg <= workStep;
            if (!busyReg) begin
                bReg     <= b;
                isDivReg <= isDiv;
            end
            if (done) begin
                busyReg  <= 1'b0;
                countReg <= '0;
            end else begin
                busyReg  <= 1'b1;
                countReg <= countReg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Accumulator execute stage: single-cycle ALU, valid/ready handshake and
// the IDLE/MUL/DIV sequencing around the iterative mul/div unit. All
// results are registered; accEn is a one-cycle write strobe.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             opValid,
    output logic             opReady,
    input  logic [3:0]       opCode,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    output logic [WIDTH-1:0] accIn,
    output logic             accEn,
    output logic [WIDTH-1:0] extOut,
    output logic             flagOut
);

    stageStateT       stateReg, stateNext;
    logic [WIDTH-1:0] accInReg, accInNext;
    logic [WIDTH-1:0] extOutReg, extOutNext;
    logic             accEnReg, accEnNext;
    logic             flagReg, flagNext;
    logic             accept;
    logic             mdStart;
    logic             mdIsDiv;
    logic             mdDone;
    logic             mdDivZero;
    logic [WIDTH-1:0] mdLo;
    logic [WIDTH-1:0] mdHi;
    logic [WIDTH:0]   addWide;
    logic [WIDTH:0]   subWide;
    opCodeT           op;

    assign op      = opCodeT'(opCode);
    assign opReady = (stateReg == ST_IDLE);
    assign accept  = opValid && opReady;
    assign mdIsDiv = (op == OP_DIV);
    assign mdStart = accept && ((op == OP_MUL) || (op == OP_DIV));
    assign addWide = {1'b0, operandA} + {1'b0, operandB};
    assign subWide = {1'b0, operandA} - {1'b0, operandB};

    assign accIn   = accInReg;
    assign accEn   = accEnReg;
    assign extOut  = extOutReg;
    assign flagOut = flagReg;

    seq_muldiv_unit #(
        .WIDTH (WIDTH)
    ) uMulDiv (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mdStart),
        .isDiv   (mdIsDiv),
        .a       (operandA),
        .b       (operandB),
        .done    (mdDone),
        .lo      (mdLo),
        .hi      (mdHi),
        .divZero (mdDivZero)
    );

    // Next-state and next-output logic; outputs hold unless an op writes them.
    always_comb begin
        stateNext  = stateReg;
        accInNext  = accInReg;
        extOutNext = extOutReg;
        flagNext   = flagReg;
        accEnNext  = 1'b0;
        case (stateReg)
            ST_IDLE: begin
                if (accept) begin
                    accEnNext = 1'b1;
                    flagNext  = 1'b0;
                    case (op)
                        OP_LD:  accInNext = operandB;
                        OP_AND: accInNext = operandA & operandB;
                        OP_OR:  accInNext = operandA | operandB;
                        OP_XOR: accInNext = operandA ^ operandB;
                        OP_NOT: accInNext = ~operandA;
                        OP_ADD: {flagNext, accInNext} = addWide;
                        OP_SUB: {flagNext, accInNext} = subWide;
                        OP_GT:  accInNext = {{(WIDTH-1){1'b0}}, operandA > operandB};
                        OP_EQ:  accInNext = {{(WIDTH-1){1'b0}}, operandA == operandB};
                        OP_LT:  accInNext = {{(WIDTH-1){1'b0}}, operandA < operandB};
                        OP_SHL: begin
                            accInNext = operandA << 1;
                            flagNext  = operandA[WIDTH-1];
                        end
                        OP_SHR: begin
                            accInNext = operandA >> 1;
                            flagNext  = operandA[0];
                        end
                        OP_MUL: begin
                            accEnNext = 1'b0;
                            flagNext  = flagReg;
                            stateNext = ST_MUL;
                        end
                        OP_DIV: begin
                            if (mdDivZero) begin
                                accInNext  = '1;
                                extOutNext = operandA;
                                flagNext   = 1'b1;
                            end else begin
                                accEnNext = 1'b0;
                                flagNext  = flagReg;
                                stateNext = ST_DIV;
                            end
                        end
                        default: begin
                            // NOP: accepted but leaves every output untouched.
                            accEnNext = 1'b0;
                            flagNext  = flagReg;
                        end
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                if (mdDone) begin
                    accInNext  = mdLo;
                    extOutNext = mdHi;
                    flagNext   = (stateReg == ST_MUL) && (mdHi != '0);
                    accEnNext  = 1'b1;
                    stateNext  = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any op in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateReg  <= ST_IDLE;
            accInReg  <= '0;
            extOutReg <= '0;
            accEnReg  <= 1'b0;
            flagReg   <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            accInReg  <= accInNext;
            extOutReg <= extOutNext;
            accEnReg  <= accEnNext;
            flagReg   <= flagNext;
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: ops are pushed to a scoreboard when
// accepted and checked (value, ext, flag, latency) when accEn pulses.
module tb_alu_exec_stage;
    import alu_exec_stage_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         opValid = 1'b0;
    logic [3:0]   opCode = 4'h0;
    logic [W-1:0] aDrv = '0;
    logic [W-1:0] operandB = '0;
    logic [W-1:0] operandA;
    logic         feedA = 1'b0;
    logic         opReady;
    logic         accEn;
    logic         flagOut;
    logic [W-1:0] accIn;
    logic [W-1:0] extOut;

    typedef struct {
        logic [W-1:0] acc;
        logic [W-1:0] ext;
        logic         flag;
        int           lat;
        int           acceptCyc;
        string        tag;
    } sbEntryT;

    sbEntryT      sbQ[$];
    int           cyc = 0;
    int           checkCount = 0;
    int           failCount = 0;
    int           enCount = 0;
    logic [W-1:0] modelExt = '0;

    assign operandA = feedA ? accIn : aDrv;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    alu_exec_stage #(
        .WIDTH (W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .opValid  (opValid),
        .opReady  (opReady),
        .opCode   (opCode),
        .operandA (operandA),
        .operandB (operandB),
        .accIn    (accIn),
        .accEn    (accEn),
        .extOut   (extOut),
        .flagOut  (flagOut)
    );

    task automatic checkVal(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checkCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checkInt(input string tag, input int obs, input int exp);
        checkCount++;
        assert (obs == exp) else begin
            failCount++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every accEn pulse must match the oldest pending op.
    always @(negedge clk) begin : monitor
        sbEntryT e;
        if (reset_n && accEn === 1'b1) begin
            enCount++;
            checkInt("accEn_expected", int'(sbQ.size() > 0), 1);
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                $display("txn %s acc=%h ext=%h flag=%b lat=%0d", e.tag, accIn, extOut, flagOut,
                         cyc - e.acceptCyc + 1);
                checkVal({e.tag, "_acc"}, accIn, e.acc);
                checkVal({e.tag, "_ext"}, extOut, e.ext);
                checkBit({e.tag, "_flag"}, flagOut, e.flag);
                checkInt({e.tag, "_lat"}, cyc - e.acceptCyc + 1, e.lat);
            end
        end
    end

    // Present an op, hold it until accepted (bounded), then record the expectation.
    task automatic sendOp(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit push, input logic [W-1:0] expAcc,
                          input logic [W-1:0] expExt, input logic expFlag, input int expLat,
                          output int waitCycles);
        bit      ready;
        bit      accepted;
        sbEntryT e;
        opCode     = op;
        aDrv       = a;
        operandB   = b;
        opValid    = 1'b1;
        waitCycles = 0;
        accepted   = 1'b0;
        for (int i = 0; i < 40 && !accepted; i++) begin
            @(negedge clk);
            #1;
            ready = opReady;
            if (!ready) waitCycles++;
            @(posedge clk);
            #1;
            if (ready) accepted = 1'b1;
        end
        opValid = 1'b0;
        checkInt({tag, "_accepted"}, int'(accepted), 1);
        if (accepted && push) begin
            e.acc       = expAcc;
            e.ext       = expExt;
            e.flag      = expFlag;
            e.lat       = expLat;
            e.acceptCyc = cyc;
            e.tag       = tag;
            sbQ.push_back(e);
        end
    endtask

    task automatic alu(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] expAcc, input logic expFlag);
        int waitCycles;
        sendOp(tag, op, a, b, 1'b1, expAcc, modelExt, expFlag, 1, waitCycles);
    endtask

    initial begin : stimulus
        int waitCycles;
        int enBefore;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkVal("rst_accIn", accIn, 8'h00);
        checkBit("rst_accEn", accEn, 1'b0);
        checkVal("rst_extOut", extOut, 8'h00);
        checkBit("rst_flagOut", flagOut, 1'b0);
        checkBit("rst_opReady", opReady, 1'b1);
        reset_n = 1'b1;

        // Back-to-back single-cycle ops with A taken from accIn
        feedA = 1'b1;
        alu("b2b_ld", OP_LD, 8'h00, 8'h3C, 8'h3C, 1'b0);
        alu("b2b_and", OP_AND, 8'h00, 8'h0F, 8'h0C, 1'b0);
        alu("b2b_or", OP_OR, 8'h00, 8'hA0, 8'hAC, 1'b0);
        feedA = 1'b0;

        // Arithmetic with carry / borrow
        alu("add_carry", OP_ADD, 8'hF0, 8'h20, 8'h10, 1'b1);
        alu("sub_borrow", OP_SUB, 8'h05, 8'h07, 8'hFE, 1'b1);
        alu("add_nocarry", OP_ADD, 8'h12, 8'h34, 8'h46, 1'b0);

        // Compares, logic and shifts
        alu("gt_true", OP_GT, 8'h09, 8'h03, 8'h01, 1'b0);
        alu("eq_false", OP_EQ, 8'h04, 8'h05, 8'h00, 1'b0);
        alu("lt_true", OP_LT, 8'h02, 8'h07, 8'h01, 1'b0);
        alu("xor", OP_XOR, 8'hF0, 8'h3C, 8'hCC, 1'b0);
        alu("not", OP_NOT, 8'h5A, 8'h00, 8'hA5, 1'b0);
        alu("shl", OP_SHL, 8'h81, 8'h00, 8'h02, 1'b1);
        alu("shr", OP_SHR, 8'h81, 8'h00, 8'h40, 1'b1);

        // NOP: accepted, no write, outputs held
        sendOp("nop", OP_NOP, 8'h11, 8'h22, 1'b0, 8'h00, 8'h00, 1'b0, 0, waitCycles);
        repeat (2) @(posedge clk);
        #1;
        checkVal("nop_accIn_held", accIn, 8'h40);
        checkBit("nop_flag_held", flagOut, 1'b1);
        checkBit("nop_opReady", opReady, 1'b1);

        // MUL with a second op held on opValid while busy
        sendOp("mul_12x34", OP_MUL, 8'h12, 8'h34, 1'b1, 8'hA8, 8'h03, 1'b1, 8, waitCycles);
        modelExt = 8'h03;
        sendOp("held_ld", OP_LD, 8'hEE, 8'h77, 1'b1, 8'h77, modelExt, 1'b0, 1, waitCycles);
        checkInt("mul_busy_cycles", waitCycles, 7);

        // DIV, normal and by zero
        sendOp("div_c8_07", OP_DIV, 8'hC8, 8'h07, 1'b1, 8'h1C, 8'h04, 1'b0, 8, waitCycles);
        modelExt = 8'h04;
        sendOp("div_by_zero", OP_DIV, 8'h55, 8'h00, 1'b1, 8'hFF, 8'h55, 1'b1, 1, waitCycles);
        modelExt = 8'h55;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a MUL
        enBefore = enCount;
        sendOp("mul_abort", OP_MUL, 8'h0F, 8'h0F, 1'b0, 8'h00, 8'h00, 1'b0, 0, waitCycles);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        checkVal("abort_accIn", accIn, 8'h00);
        checkBit("abort_accEn", accEn, 1'b0);
        checkVal("abort_extOut", extOut, 8'h00);
        checkBit("abort_flagOut", flagOut, 1'b0);
        checkBit("abort_opReady", opReady, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        modelExt = 8'h00;
        repeat (12) @(posedge clk);
        #1;
        checkInt("abort_no_accEn", enCount - enBefore, 0);
        checkVal("abort_accIn_later", accIn, 8'h00);

        // Recovery after abort: fresh MUL with zero high byte
        sendOp("mul_03x05", OP_MUL, 8'h03, 8'h05, 1'b1, 8'h0F, 8'h00, 1'b0, 8, waitCycles);
        repeat (10) @(posedge clk);
        #1;
        checkInt("sb_drained", sbQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", checkCount, failCount);
        $finish;
    end

endmodule
